sc_adder_chain_ctrl: RTL

//  Sequencer for one stochastic-computing evaluation on an N-input mux-adder chain.
//  On start it reseeds and drives the N-1 p=0.5 select streams and enables the upstream bitstream generators.
//  It then discards the chain's pipeline warm-up bits, counts 1s on the chain output for LEN cycles, and reports the count.

---
 rtl/sc_ctrl_pkg.sv | 23 ++
 rtl/sc_adder_chain_ctrl_if.sv | 29 ++
 rtl/sc_lfsr.sv | 43 ++++
 rtl/sc_adder_chain_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/sc_ctrl_pkg.sv
// Shared types and constants for the stochastic-computing chain sequencer.
// No logic; pure declarations.
// No flow control.
package sc_ctrl_pkg;

    // Sequencer states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Select-stream generator: x^16 + x^14 + x^13 + x^11 + 1
    localparam int          LFSR_W       = 16;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sc_adder_chain_ctrl_if.sv
// Host/chain-facing bundle of the sequencer: command, chain bitstreams, status.
// No logic; carries signals between host, chain and sequencer.
// No flow control beyond the start/done handshake.
interface sc_adder_chain_ctrl_if #(
    parameter int N     = 2,
    parameter int LEN_W = 10
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] len;
    logic             sum_in;
    logic             stream_en;
    logic [N-2:0]     sel;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] count;

    // Host / chain side
    modport master (
        output start, abort, len, sum_in,
        input  stream_en, sel, busy, done, count
    );

    // Sequencer side
    modport slave (
        input  start, abort, len, sum_in,
        output stream_en, sel, busy, done, count
    );
endinterface

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR, shift-left, feedback = XOR of the TAPS-selected bits.
// q updates one cycle after load/en; load has priority over en.
// No backpressure: holds its value while en is low.
module sc_lfsr
    import sc_ctrl_pkg::*;
#(
    parameter int           W    = LFSR_W,
    parameter logic [W-1:0] TAPS = LFSR_TAPS,
    parameter logic [W-1:0] SEED = DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] q
);
    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;
    logic         fb;

    // Next value: reload, advance one step, or hold
    always_comb begin
        fb     = ^(lfsr_q & TAPS);
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED;
        end else if (en) begin
            lfsr_d = {lfsr_q[W-2:0], fb};
        end
    end

    // State register; reset returns to the seed
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/sc_adder_chain_ctrl.sv
// Sequences one SC evaluation: reseed selects, discard warm-up bits, count 1s for len cycles.
// busy from start+1; done at start+WARMUP+len+1 (start+1 when len==0).
// No backpressure: start is only taken in IDLE, abort cancels with no done.
module sc_adder_chain_ctrl
    import sc_ctrl_pkg::*;
#(
    parameter int          N      = 2,
    parameter int          WARMUP = N - 2,
    parameter int          LEN_W  = 10,
    parameter logic [15:0] SEED   = DEFAULT_SEED
) (
    input  logic                   clk,
    input  logic                   rst,
    sc_adder_chain_ctrl_if.slave   bus
);
    localparam int CNT_W = max_int(LEN_W, $clog2(WARMUP + 1));
    localparam logic [CNT_W-1:0] WARM_LOAD = (WARMUP > 0) ? CNT_W'(WARMUP - 1) : '0;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [LFSR_W-1:0]  lfsr_q;
    logic               accept;
    logic               lfsr_load;
    logic               busy;
    logic               done;
    logic               lfsr_unused;

    // abort wins over start in the same cycle
    assign accept    = (state_q == ST_IDLE) && bus.start && !bus.abort;
    assign lfsr_load = accept;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.len == '0) begin
                        state_d = ST_DONE;
                    end else if (WARMUP == 0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_WARMUP;
                    end
                end
            end
            ST_WARMUP: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        busy = (state_q == ST_WARMUP) || (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // Down-counter (cycles left in phase), latched length and ones counter
    always_comb begin
        len_d   = len_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    len_d   = bus.len;
                    count_d = '0;
                    cnt_d   = (WARMUP == 0) ? (CNT_W'(bus.len) - CNT_W'(1)) : WARM_LOAD;
                end
            end
            ST_WARMUP: begin
                // len_q is nonzero here: zero-length starts bypass WARMUP
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(len_q) - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                // count cannot exceed len_q, so it never wraps
                count_d = count_q + {{(LEN_W-1){1'b0}}, bus.sum_in};
                cnt_d   = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    sc_lfsr #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .en   (busy),
        .q    (lfsr_q)
    );

    // Only the low N-1 bits feed the chain selects
    assign lfsr_unused   = ^lfsr_q;
    assign bus.sel       = lfsr_q[N-2:0];
    assign bus.stream_en = busy;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.count     = count_q;

endmodule
